cpu_fsm: RTL and testbench

CPU_FSM -- requirements
Module: cpu_fsm

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_fsm_if.sv | 20 ++
 rtl/instr_dec.sv | 13 +
 rtl/cpu_fsm.sv | 103 ++++++++++
 tb/tb_cpu_fsm.sv | 134 +++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state enum, opcode/op constants, vsel codes and control bundle for cpu_fsm
package cpu_pkg;
  typedef enum logic [2:0] {
    WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, WR_REG
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b01;
  localparam logic [1:0] VSEL_PC = 2'b10;
  localparam logic [1:0] VSEL_C = 2'b11;
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } fields_t;
  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0] vsel, shift, aluop;
  } ctl_t;
endpackage

// File: rtl/cpu_fsm_if.sv
// cpu_fsm_if: start/instruction handshake plus datapath control bundle of cpu_fsm
interface cpu_fsm_if;
  logic s;
  logic [15:0] instr;
  logic w, err;
  logic [2:0] readnum, writenum;
  logic loada, loadb, loadc, loads, asel, bsel, write;
  logic [1:0] vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;
  modport master(
    input s, instr,
    output w, err, readnum, writenum, loada, loadb, loadc, loads, asel, bsel, write,
    output vsel, shift, ALUop, sximm8, sximm5
  );
  modport slave(
    output s, instr,
    input w, err, readnum, writenum, loada, loadb, loadc, loads, asel, bsel, write,
    input vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/instr_dec.sv
// instr_dec: field split and sign extension of the latched instruction register
module instr_dec
  import cpu_pkg::*;
(
  input logic [15:0] ir,
  output fields_t f,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);
  assign f = fields_t'(ir);
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_fsm.sv
// cpu_fsm: Moore controller for MOV/ADD/CMP/AND/MVN; CPU_FSM_ILLEGAL_TRAP_EN traps illegal opcodes in HALT
module cpu_fsm
  import cpu_pkg::*;
(
  input logic clk,
  input logic reset_n,
  cpu_fsm_if.master bus
);
  state_t state, nxt;
  logic [15:0] ir;
  fields_t f;
  ctl_t ctl;
  logic w_q, movi, movr, alu, cmp;
  instr_dec u_dec (.ir(ir), .f(f), .sximm8(bus.sximm8), .sximm5(bus.sximm5));
  assign movi = f.opcode == OPC_MOV && f.op == OP_MOVI;
  assign movr = f.opcode == OPC_MOV && f.op == OP_MOVR;
  assign alu = f.opcode == OPC_ALU;
  assign cmp = alu && f.op == OP_CMP;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NXT = HALT;
  logic err_q;
  assign bus.err = err_q;
`else
  localparam state_t ILLEGAL_NXT = WAIT;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      WAIT: nxt = bus.s ? DECODE : WAIT;
      DECODE: nxt = movi ? WR_IMM : movr ? GET_B : alu ? GET_A : ILLEGAL_NXT;
      GET_A: nxt = GET_B;
      GET_B: nxt = EXEC;
      EXEC: nxt = cmp ? WAIT : WR_REG;
      WR_IMM, WR_REG: nxt = WAIT;
      default: nxt = state;
    endcase
  end
  // ir only changes on WAIT->DECODE and DECODE drives nothing, so current fields are valid for the next state
  function automatic ctl_t ctl_of(state_t st, fields_t x);
    ctl_t c = '0;
    case (st)
      GET_A: begin
        c.readnum = x.rn;
        c.loada = 1'b1;
      end
      GET_B: begin
        c.readnum = x.rm;
        c.loadb = 1'b1;
      end
      EXEC: begin
        c.shift = x.sh;
        c.loadc = 1'b1;
        c.asel = x.opcode == OPC_MOV;
        c.aluop = x.opcode == OPC_MOV ? 2'b00 : x.op;
        c.loads = x.opcode == OPC_ALU && x.op == OP_CMP;
      end
      WR_REG: begin
        c.vsel = VSEL_C;
        c.writenum = x.rd;
        c.write = 1'b1;
      end
      WR_IMM: begin
        c.vsel = VSEL_IMM;
        c.writenum = x.rn;
        c.write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= WAIT;
      ir <= '0;
      ctl <= '0;
      w_q <= 1'b1;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= nxt;
      ir <= (state == WAIT && bus.s) ? bus.instr : ir;
      ctl <= ctl_of(nxt, f);
      w_q <= nxt == WAIT;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
      err_q <= nxt == HALT;
`endif
    end
  assign bus.w = w_q;
  assign bus.readnum = ctl.readnum;
  assign bus.writenum = ctl.writenum;
  assign bus.loada = ctl.loada;
  assign bus.loadb = ctl.loadb;
  assign bus.loadc = ctl.loadc;
  assign bus.loads = ctl.loads;
  assign bus.asel = ctl.asel;
  assign bus.bsel = ctl.bsel;
  assign bus.write = ctl.write;
  assign bus.vsel = ctl.vsel;
  assign bus.shift = ctl.shift;
  assign bus.ALUop = ctl.aluop;
endmodule

// File: tb/tb_cpu_fsm.sv
// tb_cpu_fsm: random and directed instructions against a per-cycle schedule model of cpu_fsm
module tb_cpu_fsm;
  typedef struct packed {
    logic w, err;
    logic [2:0] readnum, writenum;
    logic loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0] vsel, shift, aluop;
  } obs_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  obs_t exp_q[$];
  bit halt_exp;
  cpu_fsm_if bus ();
  cpu_fsm dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  function automatic obs_t sample();
    return {bus.w, bus.err, bus.readnum, bus.writenum, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.asel, bus.bsel, bus.write, bus.vsel, bus.shift, bus.ALUop};
  endfunction
  function automatic obs_t idle();
    obs_t e = '0;
    e.w = 1'b1;
    return e;
  endfunction
  // expected outputs for each cycle after s is sampled, ending with the first WAIT cycle
  function automatic void model(logic [15:0] i);
    logic [2:0] opc = i[15:13];
    logic [1:0] op = i[12:11];
    bit movi = opc == 3'd6 && op == 2'd2;
    bit movr = opc == 3'd6 && op == 2'd0;
    bit alu = opc == 3'd5;
    bit cmp = alu && op == 2'd1;
    obs_t e;
    exp_q.delete();
    halt_exp = 0;
    exp_q.push_back('0);
    if (movi) begin
      e = '0; e.vsel = 2'd1; e.writenum = i[10:8]; e.write = 1'b1; exp_q.push_back(e);
    end else if (movr || alu) begin
      if (alu) begin
        e = '0; e.readnum = i[10:8]; e.loada = 1'b1; exp_q.push_back(e);
      end
      e = '0; e.readnum = i[2:0]; e.loadb = 1'b1; exp_q.push_back(e);
      e = '0; e.shift = i[4:3]; e.loadc = 1'b1; e.asel = movr; e.aluop = alu ? op : 2'd0;
      e.loads = cmp; exp_q.push_back(e);
      if (!cmp) begin
        e = '0; e.vsel = 2'd3; e.writenum = i[7:5]; e.write = 1'b1; exp_q.push_back(e);
      end
    end
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    else begin
      halt_exp = 1;
      repeat (3) begin
        e = '0; e.err = 1'b1; exp_q.push_back(e);
      end
    end
`endif
    if (!halt_exp) exp_q.push_back(idle());
  endfunction
  // called at a negedge in WAIT; s is randomised in every non-WAIT cycle to show it is ignored
  task automatic run(input logic [15:0] i, input int stop_after = 0);
    int v8 = int'($signed(i[7:0]));
    int v5 = int'($signed(i[4:0]));
    model(i);
    check("idle_w", 32'(bus.w), 32'd1);
    bus.s = 1'b1;
    bus.instr = i;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        check($sformatf("sximm8_%h", i), 32'(bus.sximm8), v8 & 32'hFFFF);
        check($sformatf("sximm5_%h", i), 32'(bus.sximm5), v5 & 32'hFFFF);
      end
      check($sformatf("ctl_%h_c%0d", i, k + 1), 32'(sample()), 32'(exp_q[k]));
      bus.s = (k < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
      bus.instr = 16'($urandom);
      if (stop_after != 0 && k + 1 == stop_after) break;
    end
    if (halt_exp) begin
      reset_n = 1'b0;
      @(negedge clk);
      check("halt_reset", 32'(sample()), 32'(idle()));
      reset_n = 1'b1;
    end
  endtask
  initial begin
    logic [15:0] ins;
    bus.s = 1'b0;
    bus.instr = '0;
    #12;
    check("rst_state", 32'(sample()), 32'(idle()));
    check("rst_ir", 32'(bus.sximm8), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(16'hD0FD);
    run(16'hA148);
    run(16'hAB04);
    run(16'hC0A6);
    run(16'hE000);
    run(16'hA148, 3);
    @(posedge clk);
    #1 check("pre_rst_exec", 32'(bus.loadc), 32'd1);
    #1 reset_n = 1'b0;
    bus.s = 1'b1;
    #1 check("rst_mid_exec", 32'(sample()), 32'(idle()));
    check("rst_mid_ir", 32'(bus.sximm8), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run(16'hD0FD);
    repeat (80) begin
      int r = int'($urandom_range(0, 9));
      ins = 16'($urandom);
      if (r < 4) ins[15:13] = 3'd5;
      else if (r < 8) ins[15:13] = 3'd6;
      run(ins);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
